// File: rtl/learn_pkg.sv
// Shared definitions for the neighbour-table learner: state encoding,
// default memory map and the row-index helper used by the address generator.
package learn_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_RD_NCNT,
        S_RD_KSCNT,
        S_SCAN_ADDR,
        S_SCAN_CMP,
        S_COPY_RD,
        S_COPY_WR,
        S_WR_SCNT,
        S_WR_BATT,
        S_RD_Q,
        S_WR_Q,
        S_NEW_CHK,
        S_WR_CLID,
        S_WR_NBATT,
        S_WR_NQ,
        S_WR_NCNT,
        S_DONE
    } state_t;

    localparam int unsigned DEF_KSINK_BASE  = 'h008;
    localparam int unsigned DEF_NID_BASE    = 'h048;
    localparam int unsigned DEF_CLID_BASE   = 'h0C8;
    localparam int unsigned DEF_BATT_BASE   = 'h148;
    localparam int unsigned DEF_QVAL_BASE   = 'h1C8;
    localparam int unsigned DEF_SINKID_BASE = 'h248;
    localparam int unsigned DEF_KSCNT_ADDR  = 'h688;
    localparam int unsigned DEF_NCNT_ADDR   = 'h68A;
    localparam int unsigned DEF_NSCNT_BASE  = 'h68E;

    // Element index of sinkIDs[row][col] in a table with 'stride' columns.
    function automatic int unsigned row_index(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned stride);
        return row * stride + col;
    endfunction

endpackage

// File: rtl/tbl_addr_gen.sv
// Combinational table address generator: BASE + 2*row, or
// BASE + 2*(row*MAX_SINKS + col) for the two-dimensional sinkID table.
module tbl_addr_gen
    import learn_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MAX_SINKS  = 4
) (
    input  logic [WORD_WIDTH-1:0] base,
    input  logic [WORD_WIDTH-1:0] row,
    input  logic [WORD_WIDTH-1:0] col,
    input  logic                  use_row,
    output logic [WORD_WIDTH-1:0] addr
);

    logic [WORD_WIDTH-1:0] index;

    // Arithmetic wraps at WORD_WIDTH bits, matching the byte address bus.
    always_comb begin
        index = use_row ? WORD_WIDTH'(row_index(32'(row), 32'(col), MAX_SINKS)) : row;
        addr  = base + (index << 1);
    end

endmodule

// File: rtl/learn_costs_param.sv
// Neighbour-table learner: looks up a feedback sender in the shared memory,
// refreshes a known entry or appends a new one, with start/done handshake.
module learn_costs_param
    import learn_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned MAX_NEIGHBORS = 8,
    parameter int unsigned MAX_SINKS     = 4,
    parameter int unsigned KSINK_BASE    = DEF_KSINK_BASE,
    parameter int unsigned NID_BASE      = DEF_NID_BASE,
    parameter int unsigned CLID_BASE     = DEF_CLID_BASE,
    parameter int unsigned BATT_BASE     = DEF_BATT_BASE,
    parameter int unsigned QVAL_BASE     = DEF_QVAL_BASE,
    parameter int unsigned SINKID_BASE   = DEF_SINKID_BASE,
    parameter int unsigned KSCNT_ADDR    = DEF_KSCNT_ADDR,
    parameter int unsigned NCNT_ADDR     = DEF_NCNT_ADDR,
    parameter int unsigned NSCNT_BASE    = DEF_NSCNT_BASE
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] fsourceID,
    input  logic [WORD_WIDTH-1:0] fbatteryStat,
    input  logic [WORD_WIDTH-1:0] fValue,
    input  logic [WORD_WIDTH-1:0] fclusterID,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  reinit,
    output logic                  full
);

    localparam logic [WORD_WIDTH-1:0] MAX_N = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] MAX_K = WORD_WIDTH'(MAX_SINKS);
    localparam logic [WORD_WIDTH-1:0] ONE   = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] NCNT_A  = WORD_WIDTH'(NCNT_ADDR);
    localparam logic [WORD_WIDTH-1:0] KSCNT_A = WORD_WIDTH'(KSCNT_ADDR);

    state_t                state, state_d;
    logic [WORD_WIDTH-1:0] n, n_d, k, k_d, ncnt, ncnt_d, kcnt, kcnt_d;
    logic [WORD_WIDTH-1:0] address_d, data_out_d;
    logic                  wr_en_d, done_d, reinit_d, full_d, found, found_d;
    logic [WORD_WIDTH-1:0] src_q, batt_q, val_q, clid_q;
    logic [WORD_WIDTH-1:0] ag_base, ag_row, ag_addr;
    logic                  ag_use_row;

    // Table and index selection for the shared address generator.
    always_comb begin
        ag_base    = '0;
        ag_row     = n;
        ag_use_row = 1'b0;
        unique case (state)
            S_SCAN_ADDR, S_NEW_CHK:     ag_base = WORD_WIDTH'(NID_BASE);
            S_WR_CLID:                  ag_base = WORD_WIDTH'(CLID_BASE);
            S_WR_BATT, S_WR_NBATT:      ag_base = WORD_WIDTH'(BATT_BASE);
            S_RD_Q, S_WR_Q, S_WR_NQ:    ag_base = WORD_WIDTH'(QVAL_BASE);
            S_WR_SCNT:                  ag_base = WORD_WIDTH'(NSCNT_BASE);
            S_COPY_RD: begin
                ag_base = WORD_WIDTH'(KSINK_BASE);
                ag_row  = k;
            end
            S_COPY_WR: begin
                ag_base    = WORD_WIDTH'(SINKID_BASE);
                ag_use_row = 1'b1;
            end
            default: ;
        endcase
    end

    tbl_addr_gen #(
        .WORD_WIDTH(WORD_WIDTH),
        .MAX_SINKS (MAX_SINKS)
    ) u_addr (
        .base   (ag_base),
        .row    (ag_row),
        .col    (k),
        .use_row(ag_use_row),
        .addr   (ag_addr)
    );

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state;
        address_d  = address;
        data_out_d = data_out;
        wr_en_d    = 1'b0;
        done_d     = done;
        reinit_d   = reinit;
        full_d     = full;
        found_d    = found;
        n_d        = n;
        k_d        = k;
        ncnt_d     = ncnt;
        kcnt_d     = kcnt;
        case (state)
            S_IDLE: begin
                address_d = NCNT_A;
                if (start) begin
                    state_d  = S_RD_NCNT;
                    reinit_d = 1'b0;
                    full_d   = 1'b0;
                    found_d  = 1'b0;
                    n_d      = '0;
                    k_d      = '0;
                end
            end
            S_RD_NCNT: begin
                ncnt_d    = data_in;
                address_d = KSCNT_A;
                state_d   = S_RD_KSCNT;
            end
            S_RD_KSCNT: begin
                kcnt_d  = (data_in > MAX_K) ? MAX_K : data_in;
                state_d = S_SCAN_ADDR;
            end
            S_SCAN_ADDR: begin
                if (n == ncnt) begin
                    state_d = S_NEW_CHK;
                end else begin
                    address_d = ag_addr;
                    state_d   = S_SCAN_CMP;
                end
            end
            S_SCAN_CMP: begin
                if (data_in == src_q) begin
                    found_d = 1'b1;
                    state_d = S_COPY_RD;
                end else begin
                    n_d     = n + ONE;
                    state_d = S_SCAN_ADDR;
                end
            end
            S_COPY_RD: begin
                if (k == kcnt) begin
                    state_d = S_WR_SCNT;
                end else begin
                    address_d = ag_addr;
                    state_d   = S_COPY_WR;
                end
            end
            S_COPY_WR: begin
                {address_d, data_out_d, wr_en_d} = {ag_addr, data_in, 1'b1};
                k_d     = k + ONE;
                state_d = S_COPY_RD;
            end
            S_WR_SCNT: begin
                {address_d, data_out_d, wr_en_d} = {ag_addr, kcnt, 1'b1};
                state_d = found ? S_WR_BATT : S_WR_NCNT;
            end
            S_WR_BATT: begin
                {address_d, data_out_d, wr_en_d} = {ag_addr, batt_q, 1'b1};
                state_d = S_RD_Q;
            end
            S_RD_Q: begin
                address_d = ag_addr;
                state_d   = S_WR_Q;
            end
            S_WR_Q: begin
                {address_d, data_out_d, wr_en_d} = {ag_addr, val_q, 1'b1};
                reinit_d = (data_in < val_q);
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            // A full table is reported from DONE, one cycle after entering it.
            S_NEW_CHK: begin
                if (ncnt >= MAX_N) begin
                    full_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    {address_d, data_out_d, wr_en_d} = {ag_addr, src_q, 1'b1};
                    state_d = S_WR_CLID;
                end
            end
            S_WR_CLID: begin
                {address_d, data_out_d, wr_en_d} = {ag_addr, clid_q, 1'b1};
                state_d = S_WR_NBATT;
            end
            S_WR_NBATT: begin
                {address_d, data_out_d, wr_en_d} = {ag_addr, batt_q, 1'b1};
                state_d = S_WR_NQ;
            end
            S_WR_NQ: begin
                {address_d, data_out_d, wr_en_d} = {ag_addr, val_q, 1'b1};
                state_d = S_COPY_RD;
            end
            S_WR_NCNT: begin
                {address_d, data_out_d, wr_en_d} = {NCNT_A, n + ONE, 1'b1};
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    done_d = 1'b1;
                end else begin
                    done_d  = 1'b0;
                    n_d     = '0;
                    k_d     = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state    <= S_IDLE;
            address  <= NCNT_A;
            data_out <= '0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            reinit   <= 1'b0;
            full     <= 1'b0;
            found    <= 1'b0;
            n        <= '0;
            k        <= '0;
            ncnt     <= '0;
            kcnt     <= '0;
        end else begin
            state    <= state_d;
            address  <= address_d;
            data_out <= data_out_d;
            wr_en    <= wr_en_d;
            done     <= done_d;
            reinit   <= reinit_d;
            full     <= full_d;
            found    <= found_d;
            n        <= n_d;
            k        <= k_d;
            ncnt     <= ncnt_d;
            kcnt     <= kcnt_d;
        end
    end

    // NOTE: packet latches carry no reset; they are always loaded before use.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && start) begin
            src_q  <= fsourceID;
            batt_q <= fbatteryStat;
            val_q  <= fValue;
            clid_q <= fclusterID;
        end
    end

endmodule

// File: tb/tb_learn_costs_param.sv
// Scoreboard bench for learn_costs_param: a word memory model, directed
// scenarios, expectations queued at stimulus time and popped on completion.
module tb_learn_costs_param;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] fsourceID = '0, fbatteryStat = '0, fValue = '0, fclusterID = '0;
    logic [15:0] data_in, address, data_out;
    logic        wr_en, done, reinit, full;

    learn_costs_param dut (
        .clock       (clock),
        .nreset      (nreset),
        .start       (start),
        .fsourceID   (fsourceID),
        .fbatteryStat(fbatteryStat),
        .fValue      (fValue),
        .fclusterID  (fclusterID),
        .data_in     (data_in),
        .address     (address),
        .wr_en       (wr_en),
        .data_out    (data_out),
        .done        (done),
        .reinit      (reinit),
        .full        (full)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [1024];
    logic        pre_we = 1'b0, pre_clr = 1'b0;
    logic [15:0] pre_addr = '0, pre_data = '0;
    int unsigned wr_count = 0;

    assign data_in = mem[address[10:1]];

    always @(posedge clock) begin
        if (pre_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[address[10:1]] <= data_out;
            wr_count <= wr_count + 1;
        end else if (pre_we) begin
            mem[pre_addr[10:1]] <= pre_data;
        end
    end

    typedef enum {K_MEM, K_REINIT, K_FULL, K_LAT, K_WRCNT, K_DONE, K_ADDR, K_DOUT, K_WREN} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        logic [15:0] key;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] lat, obs_reinit, obs_full;
    int unsigned wr_base = 0;

    localparam logic [15:0] NCNT  = 16'h68A;
    localparam logic [15:0] KSCNT = 16'h688;

    function automatic logic [15:0] a_nid(int n);     return 16'(32'h048 + 2 * n); endfunction
    function automatic logic [15:0] a_clid(int n);    return 16'(32'h0C8 + 2 * n); endfunction
    function automatic logic [15:0] a_batt(int n);    return 16'(32'h148 + 2 * n); endfunction
    function automatic logic [15:0] a_qval(int n);    return 16'(32'h1C8 + 2 * n); endfunction
    function automatic logic [15:0] a_nscnt(int n);   return 16'(32'h68E + 2 * n); endfunction
    function automatic logic [15:0] a_ksink(int k);   return 16'(32'h008 + 2 * k); endfunction
    function automatic logic [15:0] a_sink(int n, int k); return 16'(32'h248 + 2 * (4 * n + k)); endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(kind_e kind, logic [15:0] key);
        case (kind)
            K_MEM:    return mem[key[10:1]];
            K_REINIT: return obs_reinit;
            K_FULL:   return obs_full;
            K_LAT:    return lat;
            K_WRCNT:  return 16'(wr_count - wr_base);
            K_DONE:   return 16'(done);
            K_ADDR:   return address;
            K_DOUT:   return data_out;
            default:  return 16'(wr_en);
        endcase
    endfunction

    task automatic push(string tag, kind_e kind, logic [15:0] key, logic [15:0] exp);
        sb.push_back('{tag, kind, key, exp});
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            check(e.tag, observe(e.kind, e.key), e.exp);
        end
    endtask

    task automatic poke(logic [15:0] a, logic [15:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic clear_mem();
        pre_clr = 1'b1;
        @(negedge clock);
        pre_clr = 1'b0;
    endtask

    // One full transaction; packet inputs are scrambled after acceptance.
    task automatic run(logic [15:0] src, logic [15:0] clid, logic [15:0] batt,
                       logic [15:0] val, int hold);
        @(negedge clock);
        wr_base = wr_count;
        fsourceID = src; fclusterID = clid; fbatteryStat = batt; fValue = val;
        start = 1'b1;
        lat = 16'hFFFF;
        for (int e = 0; e < 200; e++) begin
            @(posedge clock); #1;
            if (e == 0) begin
                fsourceID = ~src; fclusterID = ~clid; fbatteryStat = ~batt; fValue = ~val;
            end
            if (done) begin
                lat = 16'(e);
                break;
            end
        end
        obs_reinit = 16'(reinit);
        obs_full   = 16'(full);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check("done_held", 16'(done), 16'd1);
        end
        @(negedge clock);
        start = 1'b0;
        @(posedge clock); #1;
        check("done_drop", 16'(done), 16'd0);
        @(posedge clock); #1;
        check("idle_addr", address, NCNT);
        @(negedge clock);
        drain();
    endtask

    task automatic setup_found(logic [15:0] q1);
        clear_mem();
        poke(NCNT, 16'd2); poke(a_nid(0), 16'd5); poke(a_nid(1), 16'd9);
        poke(KSCNT, 16'd2); poke(a_ksink(0), 16'd3); poke(a_ksink(1), 16'd7);
        poke(a_qval(1), q1);
    endtask

    task automatic expect_found(logic [15:0] exp_reinit);
        push("s_sink10", K_MEM, a_sink(1, 0), 16'd3);
        push("s_sink11", K_MEM, a_sink(1, 1), 16'd7);
        push("s_nscnt1", K_MEM, a_nscnt(1), 16'd2);
        push("s_batt1",  K_MEM, a_batt(1), 16'd50);
        push("s_qval1",  K_MEM, a_qval(1), 16'd20);
        push("s_ncnt",   K_MEM, NCNT, 16'd2);
        push("s_reinit", K_REINIT, '0, exp_reinit);
        push("s_full",   K_FULL, '0, 16'd0);
        push("s_lat",    K_LAT, '0, 16'd15);
        push("s_writes", K_WRCNT, '0, 16'd5);
    endtask

    initial begin
        // Power-on reset values.
        repeat (2) @(posedge clock);
        #1;
        push("rst_addr", K_ADDR, '0, NCNT);
        push("rst_dout", K_DOUT, '0, 16'd0);
        push("rst_wren", K_WREN, '0, 16'd0);
        push("rst_done", K_DONE, '0, 16'd0);
        drain();
        @(negedge clock);
        nreset = 1'b1;

        // Known sender at index 1, K=2, old q 10 < 20.
        setup_found(16'd10);
        expect_found(16'd1);
        run(16'd9, 16'd0, 16'd50, 16'd20, 0);

        // Reset asserted during SCAN_CMP abandons the scan.
        clear_mem();
        poke(NCNT, 16'd3); poke(a_nid(0), 16'd1); poke(a_nid(1), 16'd2); poke(a_nid(2), 16'd3);
        poke(KSCNT, 16'd1);
        @(negedge clock);
        wr_base = wr_count;
        fsourceID = 16'd77;
        start = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        nreset = 1'b0;
        start  = 1'b0;
        push("mid_addr",   K_ADDR, '0, NCNT);
        push("mid_dout",   K_DOUT, '0, 16'd0);
        push("mid_wren",   K_WREN, '0, 16'd0);
        push("mid_done",   K_DONE, '0, 16'd0);
        @(posedge clock); #1;
        obs_reinit = 16'(reinit);
        obs_full   = 16'(full);
        push("mid_reinit", K_REINIT, '0, 16'd0);
        push("mid_full",   K_FULL, '0, 16'd0);
        drain();
        @(negedge clock);
        nreset = 1'b1;
        repeat (6) @(negedge clock);
        push("mid_writes", K_WRCNT, '0, 16'd0);
        push("mid_ncnt",   K_MEM, NCNT, 16'd3);
        drain();

        // New sender appended at index 1, K=1.
        clear_mem();
        poke(NCNT, 16'd1); poke(a_nid(0), 16'd5); poke(KSCNT, 16'd1); poke(a_ksink(0), 16'd4);
        push("n_nid1",   K_MEM, a_nid(1), 16'd12);
        push("n_clid1",  K_MEM, a_clid(1), 16'd3);
        push("n_batt1",  K_MEM, a_batt(1), 16'd40);
        push("n_qval1",  K_MEM, a_qval(1), 16'd8);
        push("n_sink10", K_MEM, a_sink(1, 0), 16'd4);
        push("n_nscnt1", K_MEM, a_nscnt(1), 16'd1);
        push("n_ncnt",   K_MEM, NCNT, 16'd2);
        push("n_reinit", K_REINIT, '0, 16'd0);
        push("n_full",   K_FULL, '0, 16'd0);
        push("n_lat",    K_LAT, '0, 16'd14);
        push("n_writes", K_WRCNT, '0, 16'd7);
        run(16'd12, 16'd3, 16'd40, 16'd8, 0);

        // Table full: 8 neighbours, no match.
        clear_mem();
        poke(NCNT, 16'd8);
        for (int i = 0; i < 8; i++) poke(a_nid(i), 16'(i + 1));
        poke(KSCNT, 16'd2);
        push("f_full",   K_FULL, '0, 16'd1);
        push("f_reinit", K_REINIT, '0, 16'd0);
        push("f_writes", K_WRCNT, '0, 16'd0);
        push("f_ncnt",   K_MEM, NCNT, 16'd8);
        push("f_lat",    K_LAT, '0, 16'd21);
        run(16'd99, 16'd1, 16'd2, 16'd3, 0);

        // Handshake hold, old q 30 >= 20, then an identical second request.
        setup_found(16'd30);
        expect_found(16'd0);
        run(16'd9, 16'd0, 16'd50, 16'd20, 3);
        expect_found(16'd0);
        run(16'd9, 16'd0, 16'd50, 16'd20, 0);

        // knownSinkCount above MAX_SINKS clamps to 4; found at index 0.
        clear_mem();
        poke(NCNT, 16'd1); poke(a_nid(0), 16'd6); poke(KSCNT, 16'd9);
        for (int i = 0; i < 9; i++) poke(a_ksink(i), 16'(11 + i));
        for (int i = 0; i < 4; i++) push("c_sink", K_MEM, a_sink(0, i), 16'(11 + i));
        push("c_sink_past", K_MEM, a_sink(0, 4), 16'd0);
        push("c_nscnt0",    K_MEM, a_nscnt(0), 16'd4);
        push("c_reinit",    K_REINIT, '0, 16'd1);
        push("c_lat",       K_LAT, '0, 16'd17);
        push("c_writes",    K_WRCNT, '0, 16'd7);
        run(16'd6, 16'd0, 16'd1, 16'd5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
